// File: rtl/my_sys_mem_test_pkg.sv
// my_sys_mem_test_pkg: shared state type, latency limits and data-pattern helpers
// for the on-chip RAM self-test master and its checker. No ports.
package my_sys_mem_test_pkg;

    localparam int RL_MIN = 1;
    localparam int RL_MAX = 2;
    // Helpers compute at this width; callers truncate to DATA_W (DATA_W <= PW).
    localparam int PW = 128;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE, BWRITE, BREAD} state_t;

    function automatic logic [PW-1:0] pattern(input logic [PW-1:0] seed, input logic [PW-1:0] a);
        return seed + a;
    endfunction

    function automatic int lane_of(input logic [31:0] a, input int nb);
        return int'(a % 32'(nb));
    endfunction

    // Word after a one-hot byte write of ~p into lane: that byte is inverted.
    function automatic logic [PW-1:0] lane_expect(input logic [PW-1:0] p, input int lane);
        return p ^ (PW'(8'hFF) << (8 * lane));
    endfunction

endpackage

// File: rtl/my_sys_mem_test_master_if.sv
// my_sys_mem_test_master_if: Avalon-MM s1 bus between the test master and the RAM.
// Signals: address, clken, chipselect, write, writedata, byteenable (master -> slave),
// readdata (slave -> master).
interface my_sys_mem_test_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                clken;
    logic                chipselect;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;

    modport master (output address, clken, chipselect, write, writedata, byteenable, input readdata);
    modport slave  (input address, clken, chipselect, write, writedata, byteenable, output readdata);
endinterface

// File: rtl/my_sys_mem_test_checker.sv
// my_sys_mem_test_checker: read-latency pipe, readdata comparator, saturating error
// counter and first-mismatch address latch.
// Ports: clk, reset_n, clr (new run), issue/issue_lane/issue_addr (read on the bus this
// cycle), readdata, error_count, first_err_addr.
module my_sys_mem_test_checker
    import my_sys_mem_test_pkg::*;
#(
    parameter int          ADDR_W = 8,
    parameter int          DATA_W = 32,
    parameter int          RL     = 1,
    parameter logic [31:0] SEED   = 32'hA5A5_0000,
    parameter int          ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              issue,
    input  logic              issue_lane,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] readdata,
    output logic [ERR_W-1:0]  error_count,
    output logic [ADDR_W-1:0] first_err_addr
);
    localparam int NB = DATA_W / 8;

    typedef struct packed {
        logic              v;
        logic              lane;
        logic [ADDR_W-1:0] a;
    } ent_t;

    ent_t              pipe [RL];
    ent_t              tail;
    logic [DATA_W-1:0] pat, exp_d;
    logic              mism;

    // The tail entry lines up with the readdata of the read it describes.
    assign tail  = pipe[RL-1];
    assign pat   = DATA_W'(pattern(PW'(SEED), PW'(tail.a)));
    assign exp_d = tail.lane ? DATA_W'(lane_expect(PW'(pat), lane_of(32'(tail.a), NB))) : pat;
    assign mism  = tail.v && readdata != exp_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RL; i++) pipe[i] <= '0;
            error_count    <= '0;
            first_err_addr <= '0;
        end else begin
            pipe[0] <= {issue, issue_lane, issue_addr};
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
            if (clr) begin
                error_count    <= '0;
                first_err_addr <= '0;
            end else if (mism) begin
                if (error_count != '1) error_count <= error_count + 1'b1;
                if (error_count == '0) first_err_addr <= tail.a;
            end
        end
    end

endmodule

// File: rtl/my_sys_mem_test_master.sv
// my_sys_mem_test_master: built-in self-test initiator for the on-chip RAM s1 port.
// Writes pattern(a) = SEED + a to every word, reads everything back and counts mismatches.
// Ports: clk, reset_n (async active-low), start, busy, done (pulse), pass, error_count,
// first_err_addr, s1 (Avalon-MM master modport).
// Optional: MEM_TEST_BYTE_LANE_EN adds a one-hot byte write pass (BWRITE) and its read-back (BREAD).
module my_sys_mem_test_master
    import my_sys_mem_test_pkg::*;
#(
    parameter int          ADDR_W       = 8,
    parameter int          DATA_W       = 32,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] SEED         = 32'hA5A5_0000,
    parameter int          ERR_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  error_count,
    output logic [ADDR_W-1:0] first_err_addr,
    my_sys_mem_test_master_if.master s1
);
    localparam int NB = DATA_W / 8;
    // Out-of-range latencies are clamped into the supported window.
    localparam int RL = READ_LATENCY < RL_MIN ? RL_MIN : (READ_LATENCY > RL_MAX ? RL_MAX : READ_LATENCY);

    state_t            state;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              cs_q, wr_q, clken_q, run_start;
    logic [DATA_W-1:0] wd_q, pat_n;
    logic [NB-1:0]     be_q;
    logic [1:0]        drain_cnt;

    // Address advances only inside a pass; wrapping at the last word lands on 0
    // for the next pass, and every other state parks it at 0.
    assign addr_n    = (state == WRITE || state == READ || state == BWRITE || state == BREAD) ? addr_q + 1'b1 : '0;
    assign pat_n     = DATA_W'(pattern(PW'(SEED), PW'(addr_n)));
    assign run_start = start && (state == IDLE || state == DONE);

`ifdef MEM_TEST_BYTE_LANE_EN
    logic [NB-1:0] be_lane;
    assign be_lane = NB'(1) << lane_of(32'(addr_n), NB);
`endif

    assign s1.address    = addr_q;
    assign s1.clken      = clken_q;
    assign s1.chipselect = cs_q;
    assign s1.write      = wr_q;
    assign s1.writedata  = wd_q;
    assign s1.byteenable = be_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            clken_q   <= 1'b0;
            wd_q      <= '0;
            be_q      <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            clken_q <= 1'b1;
            addr_q  <= addr_n;
            wd_q    <= pat_n;
            be_q    <= '1;
            done    <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    state <= WRITE;
                    busy  <= 1'b1;
                    pass  <= 1'b0;
                    cs_q  <= 1'b1;
                    wr_q  <= 1'b1;
                end
                WRITE: if (addr_q == '1) begin
                    state <= READ;
                    wr_q  <= 1'b0;
                end
`ifdef MEM_TEST_BYTE_LANE_EN
                READ: if (addr_q == '1) begin
                    state <= BWRITE;
                    wr_q  <= 1'b1;
                    wd_q  <= ~pat_n;
                    be_q  <= be_lane;
                end
                BWRITE: if (addr_q == '1) begin
                    state <= BREAD;
                    wr_q  <= 1'b0;
                end else begin
                    wd_q <= ~pat_n;
                    be_q <= be_lane;
                end
                BREAD: if (addr_q == '1) begin
                    state <= DRAIN;
                    cs_q  <= 1'b0;
                end
`else
                READ: if (addr_q == '1) begin
                    state <= DRAIN;
                    cs_q  <= 1'b0;
                end
`endif
                // One extra cycle past the latency lets the last compare settle
                // into error_count before pass is sampled.
                DRAIN: if (drain_cnt == 2'(RL)) begin
                    state     <= DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    pass      <= error_count == '0;
                    drain_cnt <= '0;
                end else begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    my_sys_mem_test_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RL     (RL),
        .SEED   (SEED),
        .ERR_W  (ERR_W)
    ) u_checker (
        .clk            (clk),
        .reset_n        (reset_n),
        .clr            (run_start),
        .issue          (cs_q && !wr_q),
        .issue_lane     (state == BREAD),
        .issue_addr     (addr_q),
        .readdata       (s1.readdata),
        .error_count    (error_count),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: tb/tb_my_sys_mem_test_master.sv
// tb_my_sys_mem_test_master: directed bench with RAM models at read latency 1 and 2.
module tb_my_sys_mem_test_master;
    localparam logic [31:0] SEED = 32'hA5A5_0000;
`ifdef MEM_TEST_BYTE_LANE_EN
    localparam int MUL = 4;
    localparam int ERR_EXP = 4;
`else
    localparam int MUL = 2;
    localparam int ERR_EXP = 2;
`endif
    localparam int LAT_A = MUL * 256 + 2;
    localparam int LAT_B = MUL * 256 + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start_a, start_b, fault_a, mon_clr;
    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [15:0] err_a, err_b;
    logic [7:0]  fea_a, fea_b;
    logic [73:0] outs_a, outs_b;
    int          checks = 0, errors = 0;

    my_sys_mem_test_master_if #(.ADDR_W(8), .DATA_W(32)) ia ();
    my_sys_mem_test_master_if #(.ADDR_W(8), .DATA_W(32)) ib ();

    my_sys_mem_test_master #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .error_count(err_a), .first_err_addr(fea_a), .s1(ia)
    );
    my_sys_mem_test_master #(.READ_LATENCY(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .error_count(err_b), .first_err_addr(fea_b), .s1(ib)
    );

    assign outs_a = {busy_a, done_a, pass_a, err_a, fea_a, ia.address, ia.clken, ia.chipselect, ia.write, ia.writedata, ia.byteenable};
    assign outs_b = {busy_b, done_b, pass_b, err_b, fea_b, ib.address, ib.clken, ib.chipselect, ib.write, ib.writedata, ib.byteenable};

    // Latency-1 RAM; optionally corrupts bit 0 of reads at 0x10 and 0x80.
    logic [31:0] mem_a [256];
    logic [31:0] rd_a;
    always @(posedge clk) begin
        if (ia.clken && ia.chipselect) begin
            if (ia.write) begin
                for (int i = 0; i < 4; i++) if (ia.byteenable[i]) mem_a[ia.address][8*i +: 8] <= ia.writedata[8*i +: 8];
            end else begin
                rd_a <= mem_a[ia.address] ^ {31'd0, fault_a && (ia.address == 8'h10 || ia.address == 8'h80)};
            end
        end
    end
    assign ia.readdata = rd_a;

    // Latency-2 RAM.
    logic [31:0] mem_b [256];
    logic [31:0] rb1, rb2;
    always @(posedge clk) begin
        rb2 <= rb1;
        if (ib.clken && ib.chipselect) begin
            if (ib.write) begin
                for (int i = 0; i < 4; i++) if (ib.byteenable[i]) mem_b[ib.address][8*i +: 8] <= ib.writedata[8*i +: 8];
            end else begin
                rb1 <= mem_b[ib.address];
            end
        end
    end
    assign ib.readdata = rb2;

    // Write monitor on bus A: full-word writes must walk 0..255 with SEED+addr;
    // partial writes (byte-lane pass) are recorded separately.
    int          wr_cnt = 0, wr_bad = 0, bw_cnt = 0;
    logic [3:0]  bw_be [4];
    logic [31:0] bw_wd0;
    always @(posedge clk) begin
        if (mon_clr) begin
            wr_cnt <= 0;
            wr_bad <= 0;
            bw_cnt <= 0;
        end else if (ia.chipselect && ia.write) begin
            if (ia.byteenable == 4'hF) begin
                if (ia.address != 8'(wr_cnt) || ia.writedata != SEED + 32'(ia.address)) wr_bad <= wr_bad + 1;
                wr_cnt <= wr_cnt + 1;
            end else begin
                if (bw_cnt < 4) bw_be[bw_cnt] <= ia.byteenable;
                if (bw_cnt == 0) bw_wd0 <= ia.writedata;
                bw_cnt <= bw_cnt + 1;
            end
        end
    end

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start_b = 1'b1;
        else start_a = 1'b1;
        mon_clr = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!(sel ? done_b : done_a) && n < 3000);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; fault_a = 1'b0; mon_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (outs_a !== '0) begin errors++; $display("FAIL reset_outs_a got %h want 0", outs_a); end
        checks++; if (outs_b !== '0) begin errors++; $display("FAIL reset_outs_b got %h want 0", outs_b); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (ia.clken !== 1'b1) begin errors++; $display("FAIL clken_after_reset got %b want 1", ia.clken); end
        checks++; if ({busy_a, ia.chipselect, done_a} !== 3'b000) begin errors++; $display("FAIL idle_after_reset got %b want 000", {busy_a, ia.chipselect, done_a}); end
    endtask

    task automatic test_clean;
        int n;
        pulse_start(1'b0);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL clean_busy got %b want 1", busy_a); end
        wait_done(1'b0, n);
        checks++; if (n != LAT_A) begin errors++; $display("FAIL clean_latency got %0d want %0d", n, LAT_A); end
        checks++; if ({pass_a, busy_a} !== 2'b10) begin errors++; $display("FAIL clean_pass_busy got %b want 10", {pass_a, busy_a}); end
        checks++; if (err_a !== 16'd0 || fea_a !== 8'd0) begin errors++; $display("FAIL clean_err got %0d/%h want 0/00", err_a, fea_a); end
        checks++; if (wr_cnt != 256 || wr_bad != 0) begin errors++; $display("FAIL clean_writes got %0d bad %0d want 256 bad 0", wr_cnt, wr_bad); end
        @(posedge clk);
        #1;
        checks++; if ({done_a, pass_a} !== 2'b01) begin errors++; $display("FAIL clean_done_pulse got %b want 01", {done_a, pass_a}); end
    endtask

    task automatic test_errors;
        int n;
        fault_a = 1'b1;
        pulse_start(1'b0);
        wait_done(1'b0, n);
        fault_a = 1'b0;
        checks++; if (n != LAT_A) begin errors++; $display("FAIL err_latency got %0d want %0d", n, LAT_A); end
        checks++; if (err_a !== 16'(ERR_EXP)) begin errors++; $display("FAIL err_count got %0d want %0d", err_a, ERR_EXP); end
        checks++; if (fea_a !== 8'h10) begin errors++; $display("FAIL err_first_addr got %h want 10", fea_a); end
        checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL err_pass got %b want 0", pass_a); end
    endtask

    task automatic test_latency2;
        int n;
        pulse_start(1'b1);
        wait_done(1'b1, n);
        checks++; if (n != LAT_B) begin errors++; $display("FAIL rl2_latency got %0d want %0d", n, LAT_B); end
        checks++; if (pass_b !== 1'b1 || err_b !== 16'd0) begin errors++; $display("FAIL rl2_result got %b/%0d want 1/0", pass_b, err_b); end
    endtask

    task automatic test_reset_mid_run;
        int n;
        fault_a = 1'b1;
        pulse_start(1'b0);
        repeat (300) @(posedge clk);
        #1;
        checks++; if (err_a !== 16'd1 || busy_a !== 1'b1) begin errors++; $display("FAIL mid_pre_reset got %0d/%b want 1/1", err_a, busy_a); end
        reset_n = 1'b0;
        #1;
        checks++; if (outs_a !== '0) begin errors++; $display("FAIL mid_async_reset got %h want 0", outs_a); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (outs_a !== '0 || outs_b !== '0) begin errors++; $display("FAIL mid_reset_cycle%0d got %h/%h want 0", c, outs_a, outs_b); end
        end
        reset_n = 1'b1;
        fault_a = 1'b0;
        pulse_start(1'b0);
        wait_done(1'b0, n);
        checks++; if (n != LAT_A) begin errors++; $display("FAIL mid_latency got %0d want %0d", n, LAT_A); end
        checks++; if (pass_a !== 1'b1 || err_a !== 16'd0 || fea_a !== 8'd0) begin errors++; $display("FAIL mid_result got %b/%0d/%h want 1/0/00", pass_a, err_a, fea_a); end
    endtask

    task automatic test_held_start;
        int n;
        fault_a = 1'b1;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL held_busy got %b want 1", busy_a); end
        wait_done(1'b0, n);
        fault_a = 1'b0;
        checks++; if (n != LAT_A) begin errors++; $display("FAIL held_latency1 got %0d want %0d", n, LAT_A); end
        checks++; if (err_a !== 16'(ERR_EXP) || pass_a !== 1'b0) begin errors++; $display("FAIL held_run1 got %0d/%b want %0d/0", err_a, pass_a, ERR_EXP); end
        @(posedge clk);
        #1;
        checks++; if ({busy_a, done_a} !== 2'b10) begin errors++; $display("FAIL held_restart got %b want 10", {busy_a, done_a}); end
        checks++; if (err_a !== 16'd0 || fea_a !== 8'd0) begin errors++; $display("FAIL held_cleared got %0d/%h want 0/00", err_a, fea_a); end
        wait_done(1'b0, n);
        start_a = 1'b0;
        checks++; if (n != LAT_A) begin errors++; $display("FAIL held_latency2 got %0d want %0d", n, LAT_A); end
        checks++; if (pass_a !== 1'b1 || err_a !== 16'd0) begin errors++; $display("FAIL held_run2 got %b/%0d want 1/0", pass_a, err_a); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_a !== 1'b0 || ia.chipselect !== 1'b0) begin errors++; $display("FAIL held_no_third got %b/%b want 0/0", busy_a, ia.chipselect); end
    endtask

`ifdef MEM_TEST_BYTE_LANE_EN
    task automatic test_byte_lane;
        int n;
        pulse_start(1'b0);
        wait_done(1'b0, n);
        checks++; if (n != 1026) begin errors++; $display("FAIL bl_latency got %0d want 1026", n); end
        checks++; if ({bw_be[0], bw_be[1], bw_be[2], bw_be[3]} !== 16'h1248) begin errors++; $display("FAIL bl_be_seq got %h want 1248", {bw_be[0], bw_be[1], bw_be[2], bw_be[3]}); end
        checks++; if (bw_wd0 !== 32'h5A5A_FFFF || bw_cnt != 256) begin errors++; $display("FAIL bl_writes got %h/%0d want 5a5affff/256", bw_wd0, bw_cnt); end
        checks++; if (pass_a !== 1'b1 || err_a !== 16'd0) begin errors++; $display("FAIL bl_result got %b/%0d want 1/0", pass_a, err_a); end
    endtask
`endif

    initial begin
        test_reset();
        test_clean();
        test_errors();
        test_latency2();
        test_reset_mid_run();
        test_held_start();
`ifdef MEM_TEST_BYTE_LANE_EN
        test_byte_lane();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/my_sys_mem_test_master.md
Name: my_sys_mem_test_master

Overview:
- Avalon-MM initiator that drives the s1 slave port of the on-chip RAM: address, clken, chipselect, write, writedata, byteenable, readdata.
- On start, writes a deterministic pattern to every word, reads every word back through the slave's fixed read latency, and compares.
- Reports pass/fail, error count and first failing address.
- Used as the system's built-in memory self-test and as the simulation traffic source for the RAM.

Parameters:
- ADDR_W, 8, word-address width; DEPTH = 2**ADDR_W words.
- DATA_W, 32, data width; must be a multiple of 8; byteenable width = DATA_W/8.
- READ_LATENCY, 1, slave read latency in cycles; legal values are 1 and 2.
- SEED, 32'hA5A5_0000, pattern base: pattern(a) = SEED + a, with a zero-extended to DATA_W and the sum truncated mod 2**DATA_W.
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin test; sampled only in IDLE or DONE
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at test completion
- pass  out  1  valid while in DONE; 1 = zero errors
- error_count  out  ERR_W  mismatches in the last run; saturating
- first_err_addr  out  ADDR_W  address of the first mismatch
- address  out  ADDR_W  to s1.address
- clken  out  1  to s1.clken
- chipselect  out  1  to s1.chipselect
- write  out  1  to s1.write
- writedata  out  DATA_W  to s1.writedata
- byteenable  out  DATA_W/8  to s1.byteenable
- readdata  in  DATA_W  from s1.readdata

Behaviour:
- Reset (asynchronous assertion, synchronous release): all outputs 0; state IDLE. Reset mid-run abandons the run and leaves no residual commands.
- clken: 1 in every state after reset release.
- All outputs are registered. The slave has no waitrequest, so one command is accepted per cycle.
- States: IDLE -> WRITE -> READ -> DRAIN -> DONE; DONE returns to WRITE on start.
- Starting a run (start seen in IDLE or DONE):
  - clears error_count and first_err_addr;
  - drops pass;
  - sets busy on the next edge.
  - start while busy is ignored.
- WRITE:
  - chipselect=1, write=1, byteenable all ones, writedata = pattern(address);
  - address runs 0..DEPTH-1, one per cycle;
  - after address DEPTH-1 wraps to 0, go to READ.
- READ:
  - chipselect=1, write=0, address runs 0..DEPTH-1;
  - each issued read pushes {valid, addr} into a READ_LATENCY-deep shift pipe.
- DRAIN:
  - chipselect=0 for READ_LATENCY cycles until the pipe is empty.
- Check:
  - when the pipe output is valid, compare readdata with pattern(addr).
  - On mismatch, error_count increments (saturating at 2**ERR_W-1).
  - On the first mismatch, first_err_addr latches addr.
  - The compare runs during READ and DRAIN.
- DONE:
  - busy=0; done pulses for one cycle on entry;
  - pass = (error_count==0), held until the next start;
  - chipselect=0.
- Timing: done asserts exactly 2*DEPTH+READ_LATENCY+1 cycles after the edge that samples start (DEPTH=256, READ_LATENCY=1: 514 cycles).
- Error count, first mismatch:
  - the error on the final pipe entry is counted before done asserts;
  - first_err_addr is 0 when there are no errors.

Optional Feature:
- Macro: MEM_TEST_BYTE_LANE_EN.
- Defined:
  - after READ, adds a BWRITE pass: lane = address mod (DATA_W/8); byteenable = one-hot at that lane; writedata = ~pattern(address).
  - BWRITE is followed by a BREAD pass.
  - BREAD expects pattern(address) with that lane's byte replaced by the matching byte of ~pattern(address).
  - BREAD ends in DRAIN as normal.
  - done latency becomes 4*DEPTH+READ_LATENCY+1.
- Undefined:
  - states BWRITE and BREAD do not exist; byteenable is constant all-ones while writing.

Decomposition:
- Package my_sys_mem_test_pkg holds:
  - the state enum (IDLE, WRITE, READ, DRAIN, DONE, plus BWRITE and BREAD);
  - the pattern function;
  - the expected-value function for the byte-lane pass;
  - the legal READ_LATENCY range constants.
- Sub-module my_sys_mem_test_checker holds:
  - the latency pipe;
  - the comparator;
  - the saturating error counter;
  - the first_err_addr latch.
- The top level holds the FSM and the address counter.

Test Plan:
- Clean RAM model, DEPTH=256, READ_LATENCY=1, start pulsed once -> 256 writes at 0..255 with data 0xA5A50000..0xA5A500FF; done at cycle 514; pass=1; error_count=0.
- Model flips bit0 on reads of address 0x10 and 0x80 -> error_count=2, first_err_addr=0x10, pass=0.
- READ_LATENCY=2 with a 2-cycle model -> pass=1; done at cycle 515; no off-by-one compare errors.
- reset_n low for 3 cycles mid-READ, then start -> all outputs 0 during reset; the new run passes; no stale errors.
- start held high throughout a run -> exactly one run per start sampled in IDLE/DONE; a second run starts the cycle after DONE; error_count is cleared.
- MEM_TEST_BYTE_LANE_EN defined -> byteenable cycles 0001, 0010, 0100, 1000 in BWRITE; the model merges lanes; pass=1; done at cycle 1026.
